// File: rtl/snoop_resp_tx_if.sv
// Request, hold, CR and CD signals between the snoop-response FSM, the
// transmit stage and the ACE snoop channels, bundled as one interface.
interface snoop_resp_tx_if #(
   parameter int C_ACE_DATA_WIDTH = 128
);
   logic                        i_req_valid;
   logic                        o_req_ready;
   logic [4:0]                  i_req_crresp;
   logic [C_ACE_DATA_WIDTH-1:0] i_req_data;
   logic                        i_hold_cr;
   logic                        i_hold_cd;
   logic                        i_hold_last;
   logic                        o_crvalid;
   logic                        i_crready;
   logic [4:0]                  o_crresp;
   logic                        o_cdvalid;
   logic                        i_cdready;
   logic [C_ACE_DATA_WIDTH-1:0] o_cddata;
   logic                        o_cdlast;

   // The transmit stage itself: takes requests, drives the CR/CD channels.
   modport slave (
      input  i_req_valid, i_req_crresp, i_req_data,
      input  i_hold_cr, i_hold_cd, i_hold_last,
      input  i_crready, i_cdready,
      output o_req_ready, o_crvalid, o_crresp,
      output o_cdvalid, o_cddata, o_cdlast
   );

   // The environment: upstream FSM plus the interconnect's ready signals.
   modport master (
      output i_req_valid, i_req_crresp, i_req_data,
      output i_hold_cr, i_hold_cd, i_hold_last,
      output i_crready, i_cdready,
      input  o_req_ready, o_crvalid, o_crresp,
      input  o_cdvalid, o_cddata, o_cdlast
   );
endinterface

// File: rtl/snoop_resp_tx.sv
// Snoop response transmit stage: sends one CRRESP on the CR channel and,
// when DataTransfer is set, a full cache-line burst on the CD channel.
// CR and CD run independently; hold inputs can only delay a valid that has
// not yet been raised, so AXI stability is never violated.
module snoop_resp_tx #(
   parameter int C_ACE_DATA_WIDTH = 128,
   parameter int C_LINE_BYTES     = 64,
   parameter int C_CNT_WIDTH      = 32
) (
   input  logic                   ace_aclk,
   input  logic                   ace_aresetn,
   snoop_resp_tx_if.slave         bus,
   output logic                   o_done,
   output logic [C_CNT_WIDTH-1:0] o_resp_count,
   output logic [C_CNT_WIDTH-1:0] o_last_latency,
   output logic [1:0]             o_state
);

   localparam int BEATS  = C_LINE_BYTES * 8 / C_ACE_DATA_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_stateNext;
   logic                        r_crPending;
   logic                        r_cdPending;
   logic                        r_crvalid;
   logic                        r_cdvalid;
   logic                        r_cdlast;
   logic [4:0]                  r_crresp;
   logic [C_ACE_DATA_WIDTH-1:0] r_data;
   logic [BEAT_W-1:0]           r_beat;
   logic [C_CNT_WIDTH-1:0]      r_latency;
   logic [C_CNT_WIDTH-1:0]      r_respCount;
   logic [C_CNT_WIDTH-1:0]      r_lastLatency;
   logic                        r_done;

   logic                        w_accept;
   logic                        w_crHs;
   logic                        w_cdHs;
   logic                        w_lastBeat;
   logic                        w_crClear;
   logic                        w_cdClear;
   logic                        w_sendDone;
   logic [C_CNT_WIDTH-1:0]      w_latNext;

   assign w_accept   = bus.i_req_valid && (r_state == ST_IDLE);
   assign w_crHs     = r_crvalid && bus.i_crready;
   assign w_cdHs     = r_cdvalid && bus.i_cdready;
   assign w_lastBeat = (r_beat == BEAT_W'(BEATS - 1));
   // A side is finished if it had nothing to send or its final handshake is now.
   assign w_crClear  = !r_crPending || w_crHs;
   assign w_cdClear  = !r_cdPending || (w_cdHs && w_lastBeat);
   assign w_sendDone = (r_state == ST_SEND) && w_crClear && w_cdClear;
   assign w_latNext  = (&r_latency) ? r_latency : r_latency + C_CNT_WIDTH'(1);

   // State register.
   always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
      if (!ace_aresetn) r_state <= ST_IDLE;
      else              r_state <= w_stateNext;
   end

   // Next-state logic: IDLE -> SEND on accept, SEND -> DONE once both sides drain.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)   w_stateNext = ST_SEND;
         ST_SEND: if (w_sendDone) w_stateNext = ST_DONE;
         ST_DONE:                 w_stateNext = ST_IDLE;
         default:                 w_stateNext = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      bus.o_req_ready = (r_state == ST_IDLE);
      o_state         = r_state;
   end

   assign bus.o_crvalid  = r_crvalid;
   assign bus.o_crresp   = r_crresp;
   assign bus.o_cdvalid  = r_cdvalid;
   assign bus.o_cdlast   = r_cdlast;
   assign bus.o_cddata   = r_data + C_ACE_DATA_WIDTH'(r_beat);
   assign o_done         = r_done;
   assign o_resp_count   = r_respCount;
   assign o_last_latency = r_lastLatency;

   // Request latch plus independent CR and CD channel sequencing.
   always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
      if (!ace_aresetn) begin
         r_crPending <= 1'b0;
         r_cdPending <= 1'b0;
         r_crvalid   <= 1'b0;
         r_cdvalid   <= 1'b0;
         r_cdlast    <= 1'b0;
         r_crresp    <= '0;
         r_data      <= '0;
         r_beat      <= '0;
         r_latency   <= '0;
      end else if (w_accept) begin
         r_crresp    <= bus.i_req_crresp;
         r_data      <= bus.i_req_data;
         r_crPending <= 1'b1;
         r_cdPending <= bus.i_req_crresp[0];
         r_beat      <= '0;
         r_latency   <= '0;
      end else if (r_state == ST_SEND) begin
         r_latency <= w_latNext;
         if (w_crHs) begin
            r_crvalid   <= 1'b0;
            r_crPending <= 1'b0;
         end else if (r_crPending && !r_crvalid && !bus.i_hold_cr) begin
            r_crvalid <= 1'b1;
         end
         if (w_cdHs) begin
            r_cdvalid <= 1'b0;
            r_cdlast  <= 1'b0;
            if (w_lastBeat) r_cdPending <= 1'b0;
            else            r_beat      <= r_beat + BEAT_W'(1);
         end else if (r_cdPending && !r_cdvalid && !bus.i_hold_cd &&
                      !(w_lastBeat && bus.i_hold_last)) begin
            r_cdvalid <= 1'b1;
            r_cdlast  <= w_lastBeat;
         end
      end
   end

   // Completion pulse and statistics, captured on the SEND -> DONE edge.
   always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
      if (!ace_aresetn) begin
         r_done        <= 1'b0;
         r_respCount   <= '0;
         r_lastLatency <= '0;
      end else begin
         r_done <= w_sendDone;
         if (w_sendDone) begin
            r_respCount   <= r_respCount + C_CNT_WIDTH'(1);
            r_lastLatency <= w_latNext;
         end
      end
   end

endmodule

// File: tb/tb_snoop_resp_tx.sv
// Directed self-checking bench for snoop_resp_tx: single-cycle CR response,
// full CD burst, CR backpressure, CR hold, last-beat hold and mid-burst reset.
module tb_snoop_resp_tx;

   logic        ace_aclk;
   logic        ace_aresetn;
   logic        o_done;
   logic [31:0] o_resp_count;
   logic [31:0] o_last_latency;
   logic [1:0]  o_state;
   int          testCount;
   int          failCount;

   snoop_resp_tx_if #(.C_ACE_DATA_WIDTH(128)) bus ();

   snoop_resp_tx #(
      .C_ACE_DATA_WIDTH(128),
      .C_LINE_BYTES    (64),
      .C_CNT_WIDTH     (32)
   ) dut (
      .ace_aclk      (ace_aclk),
      .ace_aresetn   (ace_aresetn),
      .bus           (bus),
      .o_done        (o_done),
      .o_resp_count  (o_resp_count),
      .o_last_latency(o_last_latency),
      .o_state       (o_state)
   );

   // Free-running 10 ns clock.
   initial ace_aclk = 1'b0;
   always #5 ace_aclk = ~ace_aclk;

   // Advance to 1 ns past the next rising edge, where outputs are sampled.
   task automatic tick();
      @(posedge ace_aclk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one request for a single edge; returns 1 ns after the accept edge.
   task automatic applyStimulus(input logic [4:0] crresp, input logic [127:0] data);
      bus.i_req_crresp = crresp;
      bus.i_req_data   = data;
      bus.i_req_valid  = 1'b1;
      tick();
      bus.i_req_valid  = 1'b0;
   endtask

   // Every output at its reset value.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, 128'(bus.o_req_ready), 128'd1);
      checkOutput({tag, "_crvalid"},   128'(bus.o_crvalid),   128'd0);
      checkOutput({tag, "_crresp"},    128'(bus.o_crresp),    128'd0);
      checkOutput({tag, "_cdvalid"},   128'(bus.o_cdvalid),   128'd0);
      checkOutput({tag, "_cddata"},    bus.o_cddata,          128'd0);
      checkOutput({tag, "_cdlast"},    128'(bus.o_cdlast),    128'd0);
      checkOutput({tag, "_done"},      128'(o_done),          128'd0);
      checkOutput({tag, "_count"},     128'(o_resp_count),    128'd0);
      checkOutput({tag, "_latency"},   128'(o_last_latency),  128'd0);
      checkOutput({tag, "_state"},     128'(o_state),         128'd0);
   endtask

   initial begin
      int n;
      testCount        = 0;
      failCount        = 0;
      ace_aresetn      = 1'b0;
      bus.i_req_valid  = 1'b0;
      bus.i_req_crresp = '0;
      bus.i_req_data   = '0;
      bus.i_hold_cr    = 1'b0;
      bus.i_hold_cd    = 1'b0;
      bus.i_hold_last  = 1'b0;
      bus.i_crready    = 1'b1;
      bus.i_cdready    = 1'b1;

      // Reset values.
      tick();
      tick();
      checkResetOutputs("reset");
      ace_aresetn = 1'b1;
      tick();

      // 1: CR-only response, crready high: latency 2, one-cycle done.
      applyStimulus(5'h00, 128'h0);
      checkOutput("t1_state_send",  128'(o_state),         128'd1);
      checkOutput("t1_ready_low",   128'(bus.o_req_ready), 128'd0);
      checkOutput("t1_crvalid_e0",  128'(bus.o_crvalid),   128'd0);
      tick();
      checkOutput("t1_crvalid_e1",  128'(bus.o_crvalid),   128'd1);
      checkOutput("t1_cdvalid_e1",  128'(bus.o_cdvalid),   128'd0);
      tick();
      checkOutput("t1_crvalid_e2",  128'(bus.o_crvalid),   128'd0);
      checkOutput("t1_cdvalid_e2",  128'(bus.o_cdvalid),   128'd0);
      checkOutput("t1_done",        128'(o_done),          128'd1);
      checkOutput("t1_count",       128'(o_resp_count),    128'd1);
      checkOutput("t1_latency",     128'(o_last_latency),  128'd2);
      checkOutput("t1_state_done",  128'(o_state),         128'd2);
      tick();
      checkOutput("t1_done_clear",  128'(o_done),          128'd0);
      checkOutput("t1_ready_back",  128'(bus.o_req_ready), 128'd1);

      // 2: data response, seed 0x10: four spaced beats, last on 0x13.
      applyStimulus(5'h01, 128'h10);
      for (int k = 1; k <= 7; k++) begin
         tick();
         checkOutput("t2_cdvalid", 128'(bus.o_cdvalid), 128'(k % 2 == 1));
         checkOutput("t2_crvalid", 128'(bus.o_crvalid), 128'(k == 1));
         if (k % 2 == 1) begin
            checkOutput("t2_cddata", bus.o_cddata,        128'h10 + 128'((k - 1) / 2));
            checkOutput("t2_cdlast", 128'(bus.o_cdlast), 128'(k == 7));
         end
      end
      tick();
      checkOutput("t2_done",    128'(o_done),         128'd1);
      checkOutput("t2_count",   128'(o_resp_count),   128'd2);
      checkOutput("t2_latency", 128'(o_last_latency), 128'd8);
      tick();

      // 3: CR backpressure with stray requests; crresp must stay stable.
      bus.i_crready = 1'b0;
      applyStimulus(5'h04, 128'h0);
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) begin
            bus.i_req_valid  = 1'b1;
            bus.i_req_crresp = 5'h1B;
         end
         if (k == 4) bus.i_req_valid = 1'b0;
         tick();
         checkOutput("t3_crvalid",   128'(bus.o_crvalid),   128'd1);
         checkOutput("t3_crresp",    128'(bus.o_crresp),    128'h04);
         checkOutput("t3_ready_low", 128'(bus.o_req_ready), 128'd0);
         checkOutput("t3_cdvalid",   128'(bus.o_cdvalid),   128'd0);
      end
      bus.i_crready = 1'b1;
      tick();
      checkOutput("t3_crvalid_end", 128'(bus.o_crvalid),   128'd0);
      checkOutput("t3_done",        128'(o_done),          128'd1);
      checkOutput("t3_count",       128'(o_resp_count),    128'd3);
      checkOutput("t3_latency",     128'(o_last_latency),  128'd7);
      tick();
      tick();
      checkOutput("t3_not_queued",  128'(o_state),         128'd0);
      checkOutput("t3_count_hold",  128'(o_resp_count),    128'd3);

      // 4: CR held for 10 cycles; CD burst finishes first.
      bus.i_hold_cr = 1'b1;
      applyStimulus(5'h01, 128'h20);
      for (int k = 1; k <= 10; k++) begin
         tick();
         checkOutput("t4_crvalid_held", 128'(bus.o_crvalid), 128'd0);
         if (k == 7) begin
            checkOutput("t4_cdvalid_last", 128'(bus.o_cdvalid), 128'd1);
            checkOutput("t4_cdlast",       128'(bus.o_cdlast),  128'd1);
            checkOutput("t4_cddata_last",  bus.o_cddata,        128'h23);
         end
      end
      checkOutput("t4_state_send", 128'(o_state),       128'd1);
      checkOutput("t4_cd_idle",    128'(bus.o_cdvalid), 128'd0);
      bus.i_hold_cr = 1'b0;
      tick();
      checkOutput("t4_crvalid_rise", 128'(bus.o_crvalid), 128'd1);
      tick();
      checkOutput("t4_done",    128'(o_done),         128'd1);
      checkOutput("t4_count",   128'(o_resp_count),   128'd4);
      checkOutput("t4_latency", 128'(o_last_latency), 128'd12);
      tick();

      // 5: last beat held for 20 cycles, then hold toggled while valid is up.
      bus.i_hold_last = 1'b1;
      applyStimulus(5'h01, 128'h30);
      for (int k = 1; k <= 20; k++) begin
         tick();
         checkOutput("t5_cdvalid", 128'(bus.o_cdvalid), 128'(k == 1 || k == 3 || k == 5));
         if (k == 5) checkOutput("t5_cddata_b2", bus.o_cddata, 128'h32);
      end
      bus.i_hold_last = 1'b0;
      tick();
      checkOutput("t5_last_valid", 128'(bus.o_cdvalid), 128'd1);
      checkOutput("t5_last_flag",  128'(bus.o_cdlast),  128'd1);
      checkOutput("t5_last_data",  bus.o_cddata,        128'h33);
      bus.i_cdready   = 1'b0;
      bus.i_hold_last = 1'b1;
      tick();
      checkOutput("t5_stable_1",   128'(bus.o_cdvalid), 128'd1);
      checkOutput("t5_stable_lst", 128'(bus.o_cdlast),  128'd1);
      bus.i_hold_last = 1'b0;
      tick();
      checkOutput("t5_stable_2",   128'(bus.o_cdvalid), 128'd1);
      bus.i_hold_last = 1'b1;
      bus.i_cdready   = 1'b1;
      tick();
      checkOutput("t5_cdvalid_end", 128'(bus.o_cdvalid),  128'd0);
      checkOutput("t5_done",        128'(o_done),         128'd1);
      checkOutput("t5_count",       128'(o_resp_count),   128'd5);
      checkOutput("t5_latency",     128'(o_last_latency), 128'd24);
      bus.i_hold_last = 1'b0;
      tick();

      // 6: reset after beat 1 handshake, then a fresh burst from the new seed.
      applyStimulus(5'h01, 128'h40);
      tick();
      checkOutput("t6_b0_data", bus.o_cddata, 128'h40);
      tick();
      tick();
      checkOutput("t6_b1_data", bus.o_cddata, 128'h41);
      tick();
      checkOutput("t6_b1_taken", 128'(bus.o_cdvalid), 128'd0);
      ace_aresetn = 1'b0;
      #1;
      checkResetOutputs("t6_reset");
      tick();
      ace_aresetn = 1'b1;
      applyStimulus(5'h01, 128'h50);
      tick();
      checkOutput("t6_new_valid", 128'(bus.o_cdvalid), 128'd1);
      checkOutput("t6_new_data",  bus.o_cddata,        128'h50);
      checkOutput("t6_new_last",  128'(bus.o_cdlast),  128'd0);
      n = 0;
      while (!o_done && n < 20) begin
         tick();
         n++;
      end
      checkOutput("t6_done_seen", 128'(o_done), 128'd1);
      checkOutput("t6_count",     128'(o_resp_count),   128'd1);
      checkOutput("t6_latency",   128'(o_last_latency), 128'd8);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
